// File: rtl/sensor_packet_framer_if.sv
// sensor_packet_framer_if: sensor sample inputs, control inputs and the framed tx byte stream
interface sensor_packet_framer_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16
);
    logic                     enable;
    logic [1:0]               power_mode;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_urgent;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_ready;
    logic                     ovr_clr;
    logic [NUM_CH-1:0]        overrun;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     packet_sent;
    logic                     busy;
    modport slave (
        input  enable, power_mode, ch_valid, ch_urgent, ch_data, ovr_clr, tx_ready,
        output ch_ready, overrun, tx_data, tx_valid, packet_sent, busy
    );
    modport master (
        output enable, power_mode, ch_valid, ch_urgent, ch_data, ovr_clr, tx_ready,
        input  ch_ready, overrun, tx_data, tx_valid, packet_sent, busy
    );
endinterface

// File: rtl/sensor_packet_framer.sv
// sensor_packet_framer: buffers one sample per channel, picks urgent-first then round-robin, frames each grant as a checksummed byte packet
module sensor_packet_framer #(
    parameter int         NUM_CH    = 4,
    parameter int         DATA_W    = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         LOW_GAP   = 256
) (
    input logic                   clk,
    input logic                   rst,
    sensor_packet_framer_if.slave bus
);
    localparam int NB  = DATA_W / 8;
    localparam int LEN = 4 + NB;
    localparam int GW  = (LOW_GAP > 1) ? $clog2(LOW_GAP) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                        st_q, st_d;
    logic [NUM_CH-1:0]             full_q, full_d, urg_q, urg_d, ovr_q, ovr_d;
    logic [NUM_CH-1:0][DATA_W-1:0] data_q, data_d;
    logic [3:0]                    idx_q, idx_d;
    logic [7:0]                    seq_q, seq_d;
    logic [2:0]                    rr_q, rr_d, pch_q, pch_d;
    logic                          purg_q, purg_d;
    logic [DATA_W-1:0]             pdat_q, pdat_d;
    logic [GW-1:0]                 gcnt_q, gcnt_d;

    logic [NUM_CH-1:0] cap, elig, gmask;
    logic [7:0]        elig8, urg8;
    logic [2:0]        gnt, j;
    logic [DATA_W-1:0] psel;
    logic              grant, accept, last;
    logic [7:0]        hdr, csum, pay, cur;

    assign bus.ch_ready    = rst ? '0 : ({NUM_CH{bus.enable}} & ~full_q);
    assign bus.overrun     = ovr_q;
    assign bus.tx_valid    = st_q == SEND;
    assign bus.tx_data     = bus.tx_valid ? cur : 8'h00;
    assign bus.packet_sent = accept && last;
    assign bus.busy        = st_q != IDLE;
    assign cap    = bus.ch_valid & bus.ch_ready;
    assign accept = bus.tx_valid && bus.tx_ready;
    assign last   = idx_q == 4'(LEN - 1);
    assign grant  = st_q == IDLE && bus.enable && |elig;

    // Arbiter: lowest-index urgent buffer wins, otherwise round-robin starting at rr_q; sleep hides non-urgent buffers
    always_comb begin
        elig  = full_q & (bus.power_mode[1] ? urg_q : {NUM_CH{1'b1}});
        elig8 = 8'(elig);
        urg8  = 8'(urg_q);
        gnt   = '0;
        j     = '0;
        psel  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = 3'((int'(rr_q) + k) % NUM_CH);
            if (elig8[j]) gnt = j;
        end
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (elig8[k] && urg8[k]) gnt = 3'(k);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == 3'(i)) psel = data_q[i];
        end
        gmask = NUM_CH'(8'd1 << gnt);
    end

    // Current packet byte from the snapshot; checksum folds header, seq and payload
    always_comb begin
        hdr  = {purg_q, 4'b0000, pch_q};
        csum = hdr ^ seq_q;
        pay  = 8'h00;
        for (int b = 0; b < NB; b++) begin
            csum = csum ^ pdat_q[DATA_W-8-8*b +: 8];
            if (idx_q == 4'(3 + b)) pay = pdat_q[DATA_W-8-8*b +: 8];
        end
        cur = (idx_q == 4'd0) ? SYNC_BYTE :
              (idx_q == 4'd1) ? hdr :
              (idx_q == 4'd2) ? seq_q :
              last            ? csum : pay;
    end

    // Next state: channel buffers, overrun flags and the IDLE/SEND/GAP packet engine
    always_comb begin
        st_d   = st_q;
        idx_d  = idx_q;
        seq_d  = seq_q;
        rr_d   = rr_q;
        pch_d  = pch_q;
        purg_d = purg_q;
        pdat_d = pdat_q;
        gcnt_d = gcnt_q;
        data_d = data_q;
        urg_d  = urg_q;
        ovr_d  = (bus.ovr_clr ? '0 : ovr_q) | (bus.ch_valid & full_q);
        full_d = (full_q & ~(grant ? gmask : '0)) | cap;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cap[i]) begin
                data_d[i] = bus.ch_data[i*DATA_W +: DATA_W];
                urg_d[i]  = bus.ch_urgent[i];
            end
        end
        case (st_q)
            IDLE: begin
                if (grant) begin
                    st_d   = SEND;
                    idx_d  = '0;
                    pch_d  = gnt;
                    purg_d = urg8[gnt];
                    pdat_d = psel;
                end
            end
            SEND: begin
                if (accept) begin
                    idx_d = last ? 4'd0 : idx_q + 4'd1;
                    if (last) begin
                        seq_d  = seq_q + 8'd1;
                        rr_d   = (pch_q == 3'(NUM_CH - 1)) ? 3'd0 : pch_q + 3'd1;
                        gcnt_d = '0;
                        st_d   = (bus.power_mode == 2'b01) ? GAP : IDLE;
                    end
                end
            end
            GAP: begin
                gcnt_d = gcnt_q + GW'(1);
                if (gcnt_q == GW'(LOW_GAP - 1)) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            full_q <= '0;
            urg_q  <= '0;
            ovr_q  <= '0;
            data_q <= '0;
            idx_q  <= '0;
            seq_q  <= '0;
            rr_q   <= '0;
            pch_q  <= '0;
            purg_q <= 1'b0;
            pdat_q <= '0;
            gcnt_q <= '0;
        end else begin
            st_q   <= st_d;
            full_q <= full_d;
            urg_q  <= urg_d;
            ovr_q  <= ovr_d;
            data_q <= data_d;
            idx_q  <= idx_d;
            seq_q  <= seq_d;
            rr_q   <= rr_d;
            pch_q  <= pch_d;
            purg_q <= purg_d;
            pdat_q <= pdat_d;
            gcnt_q <= gcnt_d;
        end
    end
endmodule

// File: tb/tb_sensor_packet_framer.sv
// tb_sensor_packet_framer: randomized scoreboard bench for sensor_packet_framer with a transaction-level reference model
module tb_sensor_packet_framer;
    localparam int         N       = 4;
    localparam int         W       = 16;
    localparam int         NB      = W / 8;
    localparam int         LEN     = 4 + NB;
    localparam int         LOW_GAP = 256;
    localparam logic [7:0] SYNC    = 8'hA5;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sensor_packet_framer_if #(.NUM_CH(N), .DATA_W(W)) bus ();

    sensor_packet_framer #(
        .NUM_CH(N), .DATA_W(W), .SYNC_BYTE(SYNC), .LOW_GAP(LOW_GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    exp_t       exp_q[$];
    logic [7:0] seen[$];
    exp_t       mon_e;
    bit         stall_pend = 1'b0;
    logic [7:0] stall_byte;

    bit         m_full[N];
    bit         m_urg[N];
    bit         m_ovr[N];
    logic [W-1:0] m_dat[N];
    int         m_left, m_gap, m_ptr, m_seq, m_ch;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 0;
            m_urg[i]  = 0;
            m_ovr[i]  = 0;
            m_dat[i]  = '0;
        end
        m_left = 0;
        m_gap  = 0;
        m_ptr  = 0;
        m_seq  = 0;
        m_ch   = 0;
    endtask

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = bus.enable && !m_full[i];
        return r;
    endfunction

    function automatic logic [N-1:0] exp_ovr();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_ovr[i];
        return r;
    endfunction

    // urgent buffers first (lowest index), then round-robin from the pointer; sleep skips non-urgent
    function automatic int pick();
        int c;
        for (int i = 0; i < N; i++) if (m_full[i] && m_urg[i]) return i;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (m_full[c] && (!bus.power_mode[1] || m_urg[c])) return c;
        end
        return -1;
    endfunction

    task automatic push_packet(input int ch);
        logic [7:0] pk[$];
        logic [7:0] cks;
        pk.push_back(SYNC);
        pk.push_back({m_urg[ch], 4'b0000, 3'(ch)});
        pk.push_back(8'(m_seq));
        for (int b = 0; b < NB; b++) pk.push_back(8'(m_dat[ch] >> (8 * (NB - 1 - b))));
        cks = 8'h00;
        for (int i = 1; i < pk.size(); i++) cks = cks ^ pk[i];
        pk.push_back(cks);
        for (int i = 0; i < pk.size(); i++) exp_q.push_back('{b: pk[i], last: (i == pk.size() - 1)});
    endtask

    // effect of the coming clock edge given the inputs currently driven
    task automatic model_step();
        bit rdy[N];
        int g;
        for (int i = 0; i < N; i++) rdy[i] = bus.enable && !m_full[i];
        for (int i = 0; i < N; i++) m_ovr[i] = (bus.ovr_clr ? 1'b0 : m_ovr[i]) | (bus.ch_valid[i] && m_full[i]);
        if (m_left > 0) begin
            if (bus.tx_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_seq = (m_seq + 1) % 256;
                    m_ptr = (m_ch + 1) % N;
                    if (bus.power_mode == 2'b01) m_gap = LOW_GAP;
                end
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (bus.enable) begin
            g = pick();
            if (g >= 0) begin
                push_packet(g);
                m_full[g] = 0;
                m_left    = LEN;
                m_ch      = g;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.ch_valid[i] && rdy[i]) begin
                m_full[i] = 1;
                m_urg[i]  = bus.ch_urgent[i];
                m_dat[i]  = bus.ch_data[i*W +: W];
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("tx_valid", 64'(bus.tx_valid), 64'(m_left > 0));
        chk("busy", 64'(bus.busy), 64'(m_left > 0 || m_gap > 0));
        chk("ch_ready", 64'(bus.ch_ready), 64'(exp_ready()));
        chk("overrun", 64'(bus.overrun), 64'(exp_ovr()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input int ch, input logic [W-1:0] d, input bit u);
        bus.ch_valid[ch]       = 1'b1;
        bus.ch_urgent[ch]      = u;
        bus.ch_data[ch*W +: W] = d;
    endtask

    task automatic release_ch();
        bus.ch_valid  = '0;
        bus.ch_urgent = '0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ch_ready", 64'(bus.ch_ready), 64'd0);
        chk("rst_packet_sent", 64'(bus.packet_sent), 64'd0);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_ch_ready", 64'(bus.ch_ready), 64'(exp_ready()));
        chk("post_rst_overrun", 64'(bus.overrun), 64'd0);
        chk("post_rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    endtask

    task automatic check_hdrs(input string nm, input logic [7:0] e[$]);
        chk({nm, "_bytes"}, 64'(seen.size()), 64'(e.size() * LEN));
        if (seen.size() >= e.size() * LEN)
            for (int p = 0; p < e.size(); p++) chk({nm, "_hdr"}, 64'(seen[p*LEN+1]), 64'(e[p]));
    endtask

    // monitor: pop the scoreboard on each accepted byte, and watch stalled bytes stay put
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) chk("stall_hold", 64'({bus.tx_valid, bus.tx_data}), 64'({1'b1, stall_byte}));
            stall_pend = bus.tx_valid && !bus.tx_ready;
            stall_byte = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL tx_byte: got unexpected byte %02h, expected none", bus.tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tx_byte", 64'(bus.tx_data), 64'(mon_e.b));
                    chk("packet_sent", 64'(bus.packet_sent), 64'(mon_e.last));
                end
                seen.push_back(bus.tx_data);
            end else begin
                chk("packet_sent_idle", 64'(bus.packet_sent), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] t1[$];
        int cnt;
        bus.enable     = 1'b1;
        bus.power_mode = 2'b00;
        bus.ch_valid   = '0;
        bus.ch_urgent  = '0;
        bus.ch_data    = '0;
        bus.ovr_clr    = 1'b0;
        bus.tx_ready   = 1'b1;
        model_reset();
        do_reset();

        // single non-urgent sample on ch2
        seen.delete();
        load(2, 16'h1234, 0);
        tick();
        release_ch();
        idle(15);
        t1 = '{8'hA5, 8'h02, 8'h00, 8'h12, 8'h34, 8'h24};
        chk("t1_len", 64'(seen.size()), 64'(LEN));
        if (seen.size() == LEN) for (int k = 0; k < LEN; k++) chk("t1_byte", 64'(seen[k]), 64'(t1[k]));

        // all channels at once, then ch0+ch3 reload after the pointer wrapped
        do_reset();
        seen.delete();
        for (int i = 0; i < N; i++) load(i, 16'(16'h1000 * (i + 1) + i), 0);
        tick();
        release_ch();
        idle(40);
        load(0, 16'hA0A0, 0);
        load(3, 16'h3C3C, 0);
        tick();
        release_ch();
        idle(20);
        check_hdrs("t2", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h03});

        // urgent ch3 beats normal ch1
        seen.delete();
        load(1, 16'h1111, 0);
        load(3, 16'h3333, 1);
        tick();
        release_ch();
        idle(20);
        check_hdrs("t3", '{8'h83, 8'h01});

        // overrun while parked in sleep
        bus.power_mode = 2'b10;
        seen.delete();
        load(0, 16'h0F0F, 0);
        tick();
        release_ch();
        load(0, 16'hDEAD, 0);
        tick();
        release_ch();
        chk("ovr_set", 64'(bus.overrun[0]), 64'd1);
        bus.ovr_clr = 1'b1;
        tick();
        chk("ovr_clr", 64'(bus.overrun[0]), 64'd0);
        load(0, 16'hBAD0, 0);
        tick();
        release_ch();
        chk("ovr_clr_and_set", 64'(bus.overrun[0]), 64'd1);
        tick();
        bus.ovr_clr = 1'b0;
        chk("ovr_clr2", 64'(bus.overrun[0]), 64'd0);

        // sleep sends only urgent
        load(1, 16'h5151, 0);
        load(2, 16'h5252, 1);
        tick();
        release_ch();
        idle(20);
        check_hdrs("t5_sleep", '{8'h82});

        // low power releases the parked buffers with a gap after each packet
        bus.power_mode = 2'b01;
        seen.delete();
        cnt = 0;
        for (int i = 0; i < 100 && !(bus.busy && !bus.tx_valid); i++) tick();
        while (bus.busy && !bus.tx_valid && cnt < 1000) begin
            cnt++;
            tick();
        end
        chk("low_gap", 64'(cnt), 64'(LOW_GAP));
        idle(300);
        check_hdrs("t5_low", '{8'h00, 8'h01});
        bus.power_mode = 2'b00;

        // stalled packet, reset on byte 3
        load(1, 16'hCAFE, 0);
        tick();
        release_ch();
        for (int i = 0; i < 100 && m_left != LEN - 3; i++) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("reached_byte3", 64'(m_left), 64'(LEN - 3));
        do_reset();
        bus.tx_ready = 1'b1;
        seen.delete();
        load(0, 16'hBEEF, 0);
        tick();
        release_ch();
        idle(15);
        chk("post_rst_len", 64'(seen.size()), 64'(LEN));
        if (seen.size() == LEN) chk("post_rst_seq", 64'(seen[2]), 64'd0);

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            bus.ch_valid   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            bus.ch_urgent  = N'($urandom);
            bus.ch_data    = {$urandom, $urandom};
            bus.tx_ready   = $urandom_range(0, 3) != 0;
            bus.ovr_clr    = $urandom_range(0, 31) == 0;
            bus.enable     = (c % 300) < 270;
            if (c % 200 == 0) bus.power_mode = 2'($urandom_range(0, 3));
            tick();
        end

        // drain
        release_ch();
        bus.ovr_clr    = 1'b0;
        bus.enable     = 1'b1;
        bus.power_mode = 2'b00;
        bus.tx_ready   = 1'b1;
        idle(700);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sensor_packet_framer.md
Name: sensor_packet_framer

Overview:
- Parametrised multi-channel successor to the fixed temperature/humidity/motion packet path of the IoT sensor controller.
- Buffers one sample per sensor channel and arbitrates between channels. Urgent samples (e.g. motion interrupt) take priority.
- Frames each granted sample into a checksummed byte packet on a valid/ready byte stream that feeds the serial transmitter.
- Power mode changes pacing and eligibility.

Parameters:
NUM_CH, 4, number of sensor channels (1..8)
DATA_W, 16, sample width in bits; a multiple of 8, 8..64
SYNC_BYTE, 8'hA5, first byte of every packet
LOW_GAP, 256, idle cycles enforced after each packet in PWR_LOW

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  framer enable
power_mode  in  2  00 PWR_NORMAL, 01 PWR_LOW, 10 PWR_SLEEP, 11 treated as PWR_SLEEP
ch_valid  in  NUM_CH  per-channel sample strobe
ch_urgent  in  NUM_CH  per-channel urgent flag, captured with the sample
ch_data  in  NUM_CH*DATA_W  samples; channel i occupies bits [i*DATA_W +: DATA_W]
ch_ready  out  NUM_CH  channel buffer empty and enable high
ovr_clr  in  1  clears all overrun flags
overrun  out  NUM_CH  sticky per-channel drop flag
tx_data  out  8  packet byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  downstream accepts byte
packet_sent  out  1  one-cycle pulse on acceptance of the last byte
busy  out  1  high in SEND or GAP

Behaviour:
- Reset (async, any state): all buffers empty, FSM to IDLE, seq=0, round-robin pointer=0. All outputs 0 except ch_ready. ch_ready=0 while rst is high, then follows enable.
- Capture: on a clk edge with ch_valid[i] && ch_ready[i], data and urgent are stored and full[i] is set.
- Overrun: ch_valid[i] && full[i] drops the sample and sets overrun[i]. ovr_clr clears all flags. If ovr_clr and a new overrun occur in the same cycle, the flag is set.
- ch_ready[i] = enable && !full[i]. Combinational from registers only.
- Packet length LEN = 4 + DATA_W/8. Byte order:
  - byte0: SYNC_BYTE
  - byte1: {urgent, 4'b0, ch_id[2:0]}
  - byte2: seq
  - payload: DATA_W/8 bytes, MSB first
  - last byte: checksum = XOR of byte1 through the last payload byte
- FSM IDLE, SEND, GAP:
  - IDLE:
    - If enable and at least one eligible full buffer exists, grant.
    - Eligible: any full buffer in NORMAL or LOW; only urgent full buffers in SLEEP.
    - Priority: lowest-index urgent buffer. Otherwise round-robin starting at the index after the last grant.
    - On grant: snapshot the buffer into the packet register, clear full[granted] in the same edge, go to SEND with byte index 0.
  - SEND:
    - tx_valid=1 and tx_data=current byte.
    - Index advances only on tx_valid && tx_ready. tx_data is stable while stalled.
    - On acceptance of the last byte: packet_sent pulses, seq increments (255 wraps to 0), round-robin pointer updates. Next state is GAP if power_mode==PWR_LOW, else IDLE.
  - GAP: count LOW_GAP cycles, then go to IDLE. tx_valid=0.
- Latency: a sample captured at edge T with the FSM in IDLE is granted at edge T+1. tx_valid is high with SYNC_BYTE after edge T+1. ch_ready for that channel rises after edge T+1.
- An enable drop or power_mode change mid-SEND lets the current packet complete. A drop of enable blocks new grants and captures.
- An urgent sample arriving during SEND waits for packet end. Preemption is never performed.
- SLEEP keeps non-urgent buffers full (not dropped); they are sent after the return to NORMAL/LOW.

Test Plan:
- Ch2 sample 0x1234, not urgent, seq=0, tx_ready=1 → bytes A5 02 00 12 34 24, packet_sent once, next seq=1.
- All 4 channels valid in one cycle, none urgent → packets in channel order 0,1,2,3. Then ch0 and ch3 reloaded → ch0 is sent before ch3 (pointer wraps after 3).
- Ch1 normal and ch3 urgent full in the same cycle → ch3 packet first with byte1=0x83, then ch1.
- Ch0 refilled twice while its buffer is full → second sample dropped, overrun[0]=1. ovr_clr → overrun[0]=0.
- PWR_SLEEP with ch1 normal and ch2 urgent → only ch2 sent. Switch to PWR_LOW → ch1 sent; busy stays high LOW_GAP cycles after packet_sent.
- tx_ready toggling randomly mid-packet, and rst asserted on byte 3 → bytes unchanged while stalled. On reset, tx_valid=0 immediately, seq=0, all ch_ready=1 after reset release with enable=1.
